// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction-fetch stage: bus request/response,
// the F/D payload, the fetch FSM encoding and small PC/payload helpers.
package fetch_stage_pkg;

  localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;
  localparam logic [63:0] PC_STEP_DEF  = 64'd4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic [31:0] raw_instr;
    logic [63:0] pc;
    logic        stall;
  } fetch_data_t;

  // One fetched instruction with the address it came from.
  typedef struct packed {
    logic [31:0] raw_instr;
    logic [63:0] pc;
  } fetch_entry_t;

  // Instructions are word aligned; the low two bits of a target are dropped.
  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return pc & ~64'h3;
  endfunction

  // Empty F/D slot: zero instruction, stall flag raised.
  function automatic fetch_data_t bubble(input logic [63:0] pc);
    fetch_data_t f;
    f.raw_instr = 32'h0;
    f.pc        = pc;
    f.stall     = 1'b1;
    return f;
  endfunction

  // Real instruction presented to the F/D register.
  function automatic fetch_data_t present(input fetch_entry_t e);
    fetch_data_t f;
    f.raw_instr = e.raw_instr;
    f.pc        = e.pc;
    f.stall     = 1'b0;
    return f;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Single-entry holding register. Catches the instruction that returns while
// the F/D slot is occupied and stalled, so no fetched word is ever lost.
module fetch_skid_buf
  import fetch_stage_pkg::*;
(
  input  logic         clk,
  input  logic         reset,     // synchronous, active-low
  input  logic         load_i,
  input  logic         clear_i,
  input  fetch_entry_t data_i,
  output fetch_entry_t data_o,
  output logic         valid_o
);

  logic         valid_q;
  fetch_entry_t data_q;

  // Occupancy flag: clear wins over load so a flush always empties the entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
    end
  end

  // Payload storage; only meaningful while valid_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load_i) begin
      data_q <= data_i;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage. Owns the PC, runs a single-outstanding ibus
// handshake and presents one instruction per cycle to the F/D register,
// absorbing downstream stalls and execute-stage redirects.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEF,
  parameter logic [63:0] PC_STEP  = PC_STEP_DEF
) (
  input  logic        clk,
  input  logic        reset,           // synchronous, active-low
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output fetch_data_t dataF,
  output logic        dataF_valid
);

  fetch_state_t state_q;
  logic [63:0]  pc_q;
  logic [63:0]  tgt_q;
  fetch_data_t  dataF_q;
  logic         dataF_valid_q;

  logic [63:0]  redir_tgt;
  logic [63:0]  pc_inc;
  logic         data_ok;
  logic         hold_load;
  logic         hold_clear;
  logic         hold_valid;
  fetch_entry_t hold_in;
  fetch_entry_t hold_out;

  // Only one request is ever in flight, so address acceptance carries no information.
  logic addr_ok_unused;
  assign addr_ok_unused = iresp.addr_ok;

  assign data_ok   = iresp.data_ok;
  assign redir_tgt = align_pc(redirect_pc);
  assign pc_inc    = pc_q + PC_STEP;   // wraps modulo 2^64
  assign hold_in   = '{raw_instr: iresp.data, pc: pc_q};

  // Skid-buffer control: park a returning word when F/D is full and stalled;
  // drain it once the stall lifts; drop it on any redirect.
  always_comb begin
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    if (state_q == S_REQ && !redirect_valid && data_ok && dataF_valid_q && stall) begin
      hold_load = 1'b1;
    end
    if (redirect_valid || (state_q == S_HOLD && !stall)) begin
      hold_clear = 1'b1;
    end
  end

  fetch_skid_buf u_hold (
    .clk     (clk),
    .reset   (reset),
    .load_i  (hold_load),
    .clear_i (hold_clear),
    .data_i  (hold_in),
    .data_o  (hold_out),
    .valid_o (hold_valid)
  );

  // Bus request: idle while the skid entry is waiting, forced low during reset.
  always_comb begin
    ireq.valid = reset && (state_q != S_HOLD);
    ireq.addr  = pc_q;
  end

  // Fetch FSM with registered F/D outputs. Priority: reset, redirect, data_ok, stall release.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      dataF_q       <= bubble(64'h0);
      dataF_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (redirect_valid) begin
            dataF_q       <= bubble(dataF_q.pc);
            dataF_valid_q <= 1'b0;
            if (data_ok) begin
              // Response retired this cycle; the returned word is thrown away.
              pc_q <= redir_tgt;
            end else begin
              // Keep the in-flight address on the bus until its response drains.
              state_q <= S_DROP;
            end
          end else if (data_ok) begin
            pc_q <= pc_inc;
            if (!dataF_valid_q || !stall) begin
              dataF_q       <= present(hold_in);
              dataF_valid_q <= 1'b1;
            end else begin
              state_q <= S_HOLD;
            end
          end else if (dataF_valid_q && !stall) begin
            // Downstream took the instruction and nothing new arrived.
            dataF_q       <= bubble(dataF_q.pc);
            dataF_valid_q <= 1'b0;
          end
        end

        S_HOLD: begin
          if (redirect_valid) begin
            dataF_q       <= bubble(dataF_q.pc);
            dataF_valid_q <= 1'b0;
            pc_q          <= redir_tgt;
            state_q       <= S_REQ;
          end else if (!stall) begin
            dataF_q       <= present(hold_out);
            dataF_valid_q <= hold_valid;
            state_q       <= S_REQ;
          end
        end

        S_DROP: begin
          if (redirect_valid) begin
            dataF_q       <= bubble(dataF_q.pc);
            dataF_valid_q <= 1'b0;
            if (data_ok) begin
              pc_q    <= redir_tgt;
              state_q <= S_REQ;
            end
          end else if (data_ok) begin
            pc_q    <= tgt_q;
            state_q <= S_REQ;
          end
        end

        default: begin
          state_q <= S_REQ;
        end
      endcase
    end
  end

  // Pending redirect target, captured whenever the old request must drain first;
  // a later redirect during the drain replaces it.
  always_ff @(posedge clk) begin
    if (redirect_valid && !data_ok && state_q != S_HOLD) begin
      tgt_q <= redir_tgt;
    end
  end

  assign dataF       = dataF_q;
  assign dataF_valid = dataF_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random traffic,
// all compared cycle by cycle against a queue-based reference model.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  fetch_data_t dataF;
  logic        dataF_valid;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  logic [63:0] m_pc;
  logic [63:0] m_tgt;
  logic        m_drop;
  logic        m_out_v;
  logic [31:0] m_out_instr;
  logic [63:0] m_out_pc;
  logic [95:0] m_q[$];

  // Sampled DUT values for directed literal checks.
  logic        s_req_v;
  logic [63:0] s_addr;
  logic        s_dv;
  logic [63:0] s_pc;
  logic [31:0] s_instr;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .ireq           (ireq),
    .iresp          (iresp),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dataF          (dataF),
    .dataF_valid    (dataF_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_req_v(input logic r);
    return r && (m_q.size() == 0);
  endfunction

  task automatic model_reset();
    m_pc    = 64'h8000_0000;
    m_tgt   = 64'h0;
    m_drop  = 1'b0;
    m_out_v = 1'b0;
    m_out_instr = 32'h0;
    m_out_pc    = 64'h0;
    m_q.delete();
  endtask

  // One clock of abstract fetch behaviour: a PC, a "discard next response"
  // flag, an output slot and a waiting-instruction queue.
  task automatic model_step(input logic r, input logic st, input logic rv,
                            input logic [63:0] rp, input logic dok, input logic [31:0] d);
    logic [63:0] a;
    logic        was_waiting;
    logic [95:0] e;
    a = rp & ~64'h3;
    was_waiting = (m_q.size() != 0);
    if (!r) begin
      model_reset();
    end else if (rv) begin
      m_out_v = 1'b0;
      m_q.delete();
      if (was_waiting || dok) begin
        m_pc   = a;
        m_drop = 1'b0;
      end else begin
        m_drop = 1'b1;
        m_tgt  = a;
      end
    end else if (m_drop) begin
      if (dok) begin
        m_pc   = m_tgt;
        m_drop = 1'b0;
      end
    end else if (was_waiting) begin
      if (!st) begin
        e = m_q.pop_front();
        m_out_instr = e[95:64];
        m_out_pc    = e[63:0];
        m_out_v     = 1'b1;
      end
    end else if (dok) begin
      if (m_out_v && st) begin
        m_q.push_back({d, m_pc});
      end else begin
        m_out_instr = d;
        m_out_pc    = m_pc;
        m_out_v     = 1'b1;
      end
      m_pc = m_pc + 64'd4;
    end else if (!st) begin
      m_out_v = 1'b0;
    end
  endtask

  // Drive one cycle of inputs at the falling edge, compare, then advance the model at the rising edge.
  task automatic cycle(input logic r, input logic st, input logic rv,
                       input logic [63:0] rp, input logic dok, input logic [31:0] d);
    logic dok_eff;
    @(negedge clk);
    dok_eff        = dok && m_req_v(r);
    reset          = r;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rp;
    iresp.addr_ok  = dok_eff;
    iresp.data_ok  = dok_eff;
    iresp.data     = d;
    #1;
    s_req_v = ireq.valid;
    s_addr  = ireq.addr;
    s_dv    = dataF_valid;
    s_pc    = dataF.pc;
    s_instr = dataF.raw_instr;
    check_eq("req_valid", {63'h0, ireq.valid}, {63'h0, m_req_v(r)});
    check_eq("req_addr", ireq.addr, m_pc);
    check_eq("dataF_valid", {63'h0, dataF_valid}, {63'h0, m_out_v});
    check_eq("dataF_stall", {63'h0, dataF.stall}, {63'h0, !m_out_v});
    if (m_out_v) begin
      check_eq("dataF_pc", dataF.pc, m_out_pc);
      check_eq("dataF_instr", {32'h0, dataF.raw_instr}, {32'h0, m_out_instr});
    end else begin
      check_eq("bubble_instr", {32'h0, dataF.raw_instr}, 64'h0);
    end
    @(posedge clk);
    model_step(r, st, rv, rp, dok_eff, d);
  endtask

  initial begin
    reset          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    iresp          = '0;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset held: bus idle, F/D empty; release shows the first request.
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 32'h13);
    check_eq("t1_rst_req", {63'h0, s_req_v}, 64'h0);
    check_eq("t1_rst_dv", {63'h0, s_dv}, 64'h0);
    cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    check_eq("t1_req", {63'h0, s_req_v}, 64'h1);
    check_eq("t1_addr", s_addr, 64'h8000_0000);

    // Back-to-back fetch, one instruction per cycle.
    cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 32'h0000_0013);
    cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 32'h0010_0093);
    check_eq("t2_pc0", s_pc, 64'h8000_0000);
    cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 32'h0020_0113);
    check_eq("t2_pc4", s_pc, 64'h8000_0004);

    // Stall while a new word returns: parked, bus idle, then released in order.
    cycle(1'b1, 1'b1, 1'b0, 64'h0, 1'b1, 32'h0030_0193);
    check_eq("t3_pc8", s_pc, 64'h8000_0008);
    check_eq("t3_addrC", s_addr, 64'h8000_000C);
    cycle(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 32'h0);
    check_eq("t3_hold_req", {63'h0, s_req_v}, 64'h0);
    check_eq("t3_hold_pc", s_pc, 64'h8000_0008);
    cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    check_eq("t3_pcC", s_pc, 64'h8000_000C);
    check_eq("t3_instrC", {32'h0, s_instr}, 64'h0030_0193);
    check_eq("t3_addr10", s_addr, 64'h8000_0010);

    // Redirect while a request is pending: address held, response dropped.
    cycle(1'b1, 1'b0, 1'b1, 64'h8000_0100, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    check_eq("t4_addr_hold", s_addr, 64'h8000_0010);
    check_eq("t4_dv", {63'h0, s_dv}, 64'h0);
    cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 32'hDEAD_BEEF);
    cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    check_eq("t4_addr_new", s_addr, 64'h8000_0100);
    check_eq("t4_dv2", {63'h0, s_dv}, 64'h0);

    // Redirect coinciding with data_ok, unaligned target.
    cycle(1'b1, 1'b0, 1'b1, 64'h8000_0203, 1'b1, 32'hBAD0_0BAD);
    cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    check_eq("t5_addr", s_addr, 64'h8000_0200);
    check_eq("t5_dv", {63'h0, s_dv}, 64'h0);

    // PC wrap, then reset during an outstanding request.
    cycle(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 32'h0000_0073);
    check_eq("t6_addr_top", s_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    check_eq("t6_addr_wrap", s_addr, 64'h0);
    check_eq("t6_pc_top", s_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 32'h1234_5678);
    check_eq("t6_rst_req", {63'h0, s_req_v}, 64'h0);
    cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    check_eq("t6_addr_rst", s_addr, 64'h8000_0000);
    check_eq("t6_dv_rst", {63'h0, s_dv}, 64'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] rp;
      if ($urandom_range(7) == 0) rp = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
      else                        rp = {$urandom, $urandom};
      cycle($urandom_range(63) != 0, $urandom_range(2) == 0, $urandom_range(9) == 0,
            rp, $urandom_range(1) == 1, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
